// File: rtl/bali_pkg.sv
// Shared definitions for the bali bytecode CPU: opcode constants, the
// invokestatic length and the return-sequencer state encoding.
package bali_pkg;

  localparam logic [7:0] OP_INVOKESTATIC = 8'hb8;
  localparam logic [7:0] OP_IRETURN      = 8'hac;
  localparam logic [7:0] OP_ARETURN      = 8'hb0;
  localparam logic [7:0] OP_RETURN       = 8'hb1;

  localparam int INVOKE_LEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP_CALL,
    ST_WAIT_CALL,
    ST_POP_LVA,
    ST_WAIT_LVA,
    ST_FIN,
    ST_FAULT
  } ret_state_t;

  function automatic logic is_return_op(input logic [7:0] op);
    return (op == OP_IRETURN) || (op == OP_ARETURN) || (op == OP_RETURN);
  endfunction

  function automatic logic is_value_return_op(input logic [7:0] op);
    return (op == OP_IRETURN) || (op == OP_ARETURN);
  endfunction

endpackage

// File: rtl/stack_pop.sv
// Pop-side handshake for one stack: forwards the trigger, waits for the
// stack's completion and captures the popped word plus a fixed offset.
module stack_pop #(
  parameter int W   = 32,
  parameter int ADD = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fire_i,
  input  logic         done_i,
  input  logic [W-1:0] read_i,
  output logic         trigger_o,
  output logic         ack_o,
  output logic [W-1:0] word_o
);

  logic         waiting_q;
  logic [W-1:0] word_q;

  // Completions that arrive while no pop is outstanding are simply dropped.
  assign ack_o     = waiting_q & done_i;
  assign trigger_o = fire_i;
  assign word_o    = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waiting_q <= 1'b0;
      word_q    <= '0;
    end else if (fire_i) begin
      waiting_q <= 1'b1;
    end else if (ack_o) begin
      waiting_q <= 1'b0;
      word_q    <= read_i + W'(ADD);
    end
  end

endmodule

// File: rtl/return_unit.sv
// Method-return sequencer: pops call-site pc and caller LVA offset, then
// restores pc / LVA base and optionally forwards the return value.
module return_unit
  import bali_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int INVOKE_LEN = bali_pkg::INVOKE_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  op_code,
  input  logic [31:0] ret_in,
  input  logic        frame_pushed,
  output logic        callstack_push,
  output logic        callstack_trigger,
  input  logic [31:0] callstack_read,
  input  logic        callstack_done,
  output logic        lvastack_push,
  output logic        lvastack_trigger,
  input  logic [31:0] lvastack_read,
  input  logic        lvastack_done,
  output logic [15:0] pc_out,
  output logic        pc_load,
  output logic [7:0]  lva_offset_out,
  output logic        lva_offset_load,
  output logic [31:0] ret_out,
  output logic        ret_valid,
  output logic        busy,
  output logic        done,
  output logic        underflow,
  output logic        overflow
);

  localparam int              FW   = $clog2(DEPTH + 1);
  localparam logic [FW-1:0]   FULL = FW'(DEPTH);

  ret_state_t    state_q;
  logic [FW-1:0] frames_q, frames_d;
  logic          value_q;
  logic [31:0]   ret_q, ret_out_q;
  logic          call_fire_q, lva_fire_q;
  logic          pc_load_q, lva_load_q, ret_valid_q, done_q, underflow_q, overflow_q;
  logic          call_ack, lva_ack, accept, pop, ovf_d;
  logic          unused_bits;

  stack_pop #(.W(16), .ADD(INVOKE_LEN)) u_call_pop (
    .clk      (clk),
    .rst_n    (rst_n),
    .fire_i   (call_fire_q),
    .done_i   (callstack_done),
    .read_i   (callstack_read[15:0]),
    .trigger_o(callstack_trigger),
    .ack_o    (call_ack),
    .word_o   (pc_out)
  );

  stack_pop #(.W(8), .ADD(0)) u_lva_pop (
    .clk      (clk),
    .rst_n    (rst_n),
    .fire_i   (lva_fire_q),
    .done_i   (lvastack_done),
    .read_i   (lvastack_read[7:0]),
    .trigger_o(lvastack_trigger),
    .ack_o    (lva_ack),
    .word_o   (lva_offset_out)
  );

  assign unused_bits = ^{callstack_read[31:16], lvastack_read[31:8]};

  assign accept = start && (state_q == ST_IDLE) && is_return_op(op_code);
  assign pop    = (state_q == ST_FIN);

  // A push coinciding with the FIN pop cancels out; a push at DEPTH saturates.
  always_comb begin
    frames_d = frames_q;
    ovf_d    = 1'b0;
    if (frame_pushed && !pop) begin
      if (frames_q == FULL) ovf_d = 1'b1;
      else                  frames_d = frames_q + FW'(1);
    end else if (!frame_pushed && pop) begin
      frames_d = frames_q - FW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frames_q    <= '0;
      value_q     <= 1'b0;
      ret_q       <= '0;
      ret_out_q   <= '0;
      call_fire_q <= 1'b0;
      lva_fire_q  <= 1'b0;
      pc_load_q   <= 1'b0;
      lva_load_q  <= 1'b0;
      ret_valid_q <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      call_fire_q <= 1'b0;
      lva_fire_q  <= 1'b0;
      pc_load_q   <= 1'b0;
      lva_load_q  <= 1'b0;
      ret_valid_q <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= ovf_d;
      frames_q    <= frames_d;
      case (state_q)
        ST_IDLE: if (accept) begin
          if (frames_q == '0) begin
            done_q      <= 1'b1;
            underflow_q <= 1'b1;
            state_q     <= ST_FAULT;
          end else begin
            value_q     <= is_value_return_op(op_code);
            ret_q       <= ret_in;
            call_fire_q <= 1'b1;
            state_q     <= ST_POP_CALL;
          end
        end
        ST_POP_CALL:  state_q <= ST_WAIT_CALL;
        ST_WAIT_CALL: if (call_ack) begin
          lva_fire_q <= 1'b1;
          state_q    <= ST_POP_LVA;
        end
        ST_POP_LVA:   state_q <= ST_WAIT_LVA;
        // Strobes are raised on entry so they are visible exactly in the FIN cycle.
        ST_WAIT_LVA: if (lva_ack) begin
          pc_load_q   <= 1'b1;
          lva_load_q  <= 1'b1;
          done_q      <= 1'b1;
          ret_valid_q <= value_q;
          if (value_q) ret_out_q <= ret_q;
          state_q     <= ST_FIN;
        end
        ST_FIN:   state_q <= ST_IDLE;
        ST_FAULT: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign callstack_push  = 1'b0;
  assign lvastack_push   = 1'b0;
  assign pc_load         = pc_load_q;
  assign lva_offset_load = lva_load_q;
  assign ret_out         = ret_out_q;
  assign ret_valid       = ret_valid_q;
  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign underflow       = underflow_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_return_unit.sv
// Self-checking bench for return_unit: directed scenarios plus randomized
// returns checked against a frame-count / latency model of the sequencer.
module tb_return_unit;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  op_code;
  logic [31:0] ret_in;
  logic        frame_pushed;
  logic        callstack_push, callstack_trigger, callstack_done;
  logic [31:0] callstack_read;
  logic        lvastack_push, lvastack_trigger, lvastack_done;
  logic [31:0] lvastack_read;
  logic [15:0] pc_out;
  logic        pc_load;
  logic [7:0]  lva_offset_out;
  logic        lva_offset_load;
  logic [31:0] ret_out;
  logic        ret_valid, busy, done, underflow, overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state: number of frames the unit should currently hold.
  int modelFrames = 0;

  // Stack responder configuration: cycles from trigger to done, and the word popped.
  int          callLat  = 1;
  int          lvaLat   = 1;
  logic [31:0] callWord = '0;
  logic [31:0] lvaWord  = '0;

  return_unit #(.DEPTH(DEPTH), .INVOKE_LEN(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .op_code          (op_code),
    .ret_in           (ret_in),
    .frame_pushed     (frame_pushed),
    .callstack_push   (callstack_push),
    .callstack_trigger(callstack_trigger),
    .callstack_read   (callstack_read),
    .callstack_done   (callstack_done),
    .lvastack_push    (lvastack_push),
    .lvastack_trigger (lvastack_trigger),
    .lvastack_read    (lvastack_read),
    .lvastack_done    (lvastack_done),
    .pc_out           (pc_out),
    .pc_load          (pc_load),
    .lva_offset_out   (lva_offset_out),
    .lva_offset_load  (lva_offset_load),
    .ret_out          (ret_out),
    .ret_valid        (ret_valid),
    .busy             (busy),
    .done             (done),
    .underflow        (underflow),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Call-stack model: answers a trigger with done after callLat cycles; read is noise otherwise.
  initial begin
    callstack_done = 1'b0;
    callstack_read = '0;
    forever begin
      @(negedge clk);
      if (callstack_trigger === 1'b1) begin
        repeat (callLat) @(negedge clk);
        callstack_done = 1'b1;
        callstack_read = callWord;
        @(negedge clk);
        callstack_done = 1'b0;
        callstack_read = $urandom();
      end
    end
  end

  // LVA-offset stack model, same behaviour with its own latency.
  initial begin
    lvastack_done = 1'b0;
    lvastack_read = '0;
    forever begin
      @(negedge clk);
      if (lvastack_trigger === 1'b1) begin
        repeat (lvaLat) @(negedge clk);
        lvastack_done = 1'b1;
        lvastack_read = lvaWord;
        @(negedge clk);
        lvastack_done = 1'b0;
        lvastack_read = $urandom();
      end
    end
  end

  // Hold reset for a cycle, check the reset state, then release.
  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; frame_pushed = 1'b0; op_code = '0; ret_in = '0;
    @(negedge clk);
    checkOutput("rst_pc_out", 32'(pc_out), 32'h0);
    checkOutput("rst_lva_out", 32'(lva_offset_out), 32'h0);
    checkOutput("rst_ret_out", ret_out, 32'h0);
    checkOutput("rst_strobes", 32'({pc_load, lva_offset_load, ret_valid, done, underflow, overflow}), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_stack_ctl", 32'({callstack_push, callstack_trigger, lvastack_push, lvastack_trigger}), 32'h0);
    rst_n = 1'b1;
    modelFrames = 0;
    @(negedge clk);
  endtask

  // One frame_pushed pulse; overflow expected only when the model is already full.
  task automatic pushOne();
    bit expOv;
    expOv = (modelFrames == DEPTH);
    @(negedge clk);
    frame_pushed = 1'b1;
    @(negedge clk);
    frame_pushed = 1'b0;
    checkOutput("overflow", 32'(overflow), 32'(expOv));
    if (expOv) begin
      @(negedge clk);
      checkOutput("overflow_one_cycle", 32'(overflow), 32'h0);
    end else begin
      modelFrames++;
    end
  endtask

  // Issue one start and predict everything from the opcode class and the model frame count.
  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] rv, input logic [15:0] cw,
                               input logic [7:0] lw, input int lc, input int ld,
                               input bit pushAtFin, input bit startWhileBusy);
    bit          isRet, isVal, expFault, success, busyDuring, busyAfter, pushHigh;
    int          expDone, lastLat, doneLat, doneCnt, ufCnt;
    int          callTrigLat, lvaTrigLat, callTrigCnt, lvaTrigCnt, pcLoadCnt, lvaLoadCnt, retValidCnt;
    logic [15:0] expPc, pcSeen;
    logic [7:0]  lvaSeen;
    logic [31:0] retSeen;

    isRet    = (op == 8'hac) || (op == 8'hb0) || (op == 8'hb1);
    isVal    = isRet && (op != 8'hb1);
    expFault = isRet && (modelFrames == 0);
    success  = isRet && !expFault;
    expDone  = !isRet ? -1 : (expFault ? 1 : 3 + lc + ld);
    lastLat  = (expDone < 0) ? 4 : expDone + 3;
    expPc    = cw + 16'd3;

    doneLat = -1; doneCnt = 0; ufCnt = 0;
    callTrigLat = -1; lvaTrigLat = -1; callTrigCnt = 0; lvaTrigCnt = 0;
    pcLoadCnt = 0; lvaLoadCnt = 0; retValidCnt = 0;
    pcSeen = '0; lvaSeen = '0; retSeen = '0;
    busyDuring = 1'b0; busyAfter = 1'b0; pushHigh = 1'b0;

    callLat  = lc;
    lvaLat   = ld;
    callWord = {16'($urandom()), cw};
    lvaWord  = {24'($urandom()), lw};

    @(negedge clk);
    start = 1'b1; op_code = op; ret_in = rv;
    for (int lat = 1; lat <= lastLat; lat++) begin
      @(negedge clk);
      start        = startWhileBusy && (lat == 2);
      ret_in       = $urandom();
      frame_pushed = pushAtFin && (lat == expDone);
      if (done) begin
        doneCnt++;
        if (doneLat < 0) begin
          doneLat = lat;
          pcSeen  = pc_out;
          lvaSeen = lva_offset_out;
        end
      end
      if (underflow) ufCnt++;
      if (callstack_trigger) begin
        callTrigCnt++;
        if (callTrigLat < 0) callTrigLat = lat;
      end
      if (lvastack_trigger) begin
        lvaTrigCnt++;
        if (lvaTrigLat < 0) lvaTrigLat = lat;
      end
      if (pc_load) pcLoadCnt++;
      if (lva_offset_load) lvaLoadCnt++;
      if (ret_valid) begin
        retValidCnt++;
        retSeen = ret_out;
      end
      if (callstack_push || lvastack_push) pushHigh = 1'b1;
      if (lat == 1) busyDuring = busy;
      if (lat == lastLat) busyAfter = busy;
    end
    start = 1'b0;
    frame_pushed = 1'b0;

    checkOutput("done_count", 32'(doneCnt), 32'(isRet));
    checkOutput("underflow_count", 32'(ufCnt), 32'(expFault));
    checkOutput("busy_after_start", 32'(busyDuring), 32'(isRet));
    checkOutput("busy_after_done", 32'(busyAfter), 32'h0);
    checkOutput("push_lines_low", 32'(pushHigh), 32'h0);
    checkOutput("call_trigger_count", 32'(callTrigCnt), 32'(success));
    checkOutput("lva_trigger_count", 32'(lvaTrigCnt), 32'(success));
    checkOutput("pc_load_count", 32'(pcLoadCnt), 32'(success));
    checkOutput("lva_load_count", 32'(lvaLoadCnt), 32'(success));
    checkOutput("ret_valid_count", 32'(retValidCnt), 32'(success && isVal));
    if (isRet) checkOutput("done_latency", 32'(doneLat), 32'(expDone));
    if (success) begin
      checkOutput("call_trigger_cycle", 32'(callTrigLat), 32'd1);
      checkOutput("lva_trigger_cycle", 32'(lvaTrigLat), 32'(2 + lc));
      checkOutput("pc_out_at_done", 32'(pcSeen), 32'(expPc));
      checkOutput("lva_out_at_done", 32'(lvaSeen), 32'(lw));
      checkOutput("pc_out_stable", 32'(pc_out), 32'(expPc));
      checkOutput("lva_out_stable", 32'(lva_offset_out), 32'(lw));
      if (isVal) checkOutput("ret_out", retSeen, rv);
      modelFrames = modelFrames - 1 + (pushAtFin ? 1 : 0);
    end
  endtask

  initial begin
    int          cnt;
    int          nPush, sel, lc, ld;
    logic [7:0]  op;
    bit          pf, sb;

    rst_n = 1'b0; start = 1'b0; op_code = '0; ret_in = '0; frame_pushed = 1'b0;
    resetDut();

    $display("[TB] directed returns");
    applyStimulus(8'hac, 32'hDEADBEEF, 16'h0010, 8'h20, 1, 1, 1'b0, 1'b0);
    pushOne();
    pushOne();
    applyStimulus(8'hac, 32'hDEADBEEF, 16'h0010, 8'h20, 1, 1, 1'b0, 1'b0);
    applyStimulus(8'hb1, 32'h12345678, 16'h0ABC, 8'h11, 4, 4, 1'b0, 1'b0);
    applyStimulus(8'hac, 32'h00000001, 16'h1234, 8'h01, 1, 1, 1'b0, 1'b0);
    pushOne();
    applyStimulus(8'hb0, 32'hCAFEF00D, 16'hFFFE, 8'h05, 1, 1, 1'b1, 1'b0);
    applyStimulus(8'hb1, 32'h0, 16'h0100, 8'h07, 2, 1, 1'b0, 1'b1);
    applyStimulus(8'hb1, 32'h0, 16'h0200, 8'h08, 1, 1, 1'b0, 1'b0);
    pushOne();
    applyStimulus(8'h60, 32'h55AA55AA, 16'h0300, 8'h09, 1, 1, 1'b0, 1'b0);

    $display("[TB] reset during WAIT_LVA");
    callLat = 1; lvaLat = 6;
    callWord = 32'h0000_4000; lvaWord = 32'h0000_0033;
    @(negedge clk);
    start = 1'b1; op_code = 8'hb1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("mid_sequence_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_pc_out", 32'(pc_out), 32'h0);
    checkOutput("abort_lva_out", 32'(lva_offset_out), 32'h0);
    checkOutput("abort_strobes", 32'({pc_load, lva_offset_load, ret_valid, done, lvastack_trigger}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    modelFrames = 0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || pc_load || lva_offset_load || lvastack_trigger || callstack_trigger || busy) cnt++;
    end
    checkOutput("late_done_ignored", 32'(cnt), 32'h0);
    applyStimulus(8'hac, 32'h1, 16'h0001, 8'h01, 1, 1, 1'b0, 1'b0);

    $display("[TB] randomized returns");
    for (int it = 0; it < 40; it++) begin
      nPush = $urandom_range(0, 2);
      repeat (nPush) pushOne();
      sel = $urandom_range(0, 4);
      case (sel)
        0:       op = 8'hac;
        1:       op = 8'hb0;
        2, 4:    op = 8'hb1;
        default: begin
          op = 8'($urandom());
          if (op == 8'hac || op == 8'hb0 || op == 8'hb1) op = 8'h60;
        end
      endcase
      lc = $urandom_range(1, 3);
      ld = $urandom_range(1, 3);
      pf = ($urandom_range(0, 3) == 0) && (modelFrames > 0);
      sb = ($urandom_range(0, 1) == 1) && (modelFrames > 0);
      applyStimulus(op, $urandom(), 16'($urandom()), 8'($urandom()), lc, ld, pf, sb);
    end

    $display("[TB] frame counter saturation");
    resetDut();
    repeat (DEPTH) pushOne();
    pushOne();
    pushOne();
    repeat (DEPTH) applyStimulus(8'hb1, 32'h0, 16'($urandom()), 8'($urandom()), 1, 1, 1'b0, 1'b0);
    applyStimulus(8'hb1, 32'h0, 16'h0040, 8'h02, 1, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Bound on total run time so a stuck sequence can never hang the simulation.
  initial begin
    #10000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
